// File: rtl/rni_misc_pkg.sv
// Purpose : shared one-hot helpers for RNI control blocks (rotate-left, one-hot -> binary).
// Latency : pure functions, no state.
// Backpressure : not applicable.
// Contents: MAX_W / MAX_LOG2_W bounds, onehot_rotl1(), onehot_encode().
package rni_misc_pkg;

  // Upper bound on vector width handled by the helpers; callers pass their real width.
  localparam int MAX_W      = 64;
  localparam int MAX_LOG2_W = $clog2(MAX_W);

  // Rotate a w-bit one-hot vector left by one; bit w-1 wraps to bit 0.
  function automatic logic [MAX_W-1:0] onehot_rotl1(input logic [MAX_W-1:0] v,
                                                    input int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 1; i < MAX_W; i++) begin
      if (i < w) r[i] = v[i-1];
    end
    r[0] = v[w-1];
    return r;
  endfunction

  // Binary index of the set bit in a w-bit one-hot vector (0 for an all-zero vector).
  function automatic logic [MAX_LOG2_W-1:0] onehot_encode(input logic [MAX_W-1:0] v,
                                                          input int unsigned w);
    logic [MAX_LOG2_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if ((i < w) && v[i]) idx = idx | MAX_LOG2_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rni_sel_bit_from_vec.sv
// Purpose : first-one selector starting at a one-hot pointer, wrapping to bit 0.
// Latency : combinational.
// Backpressure : none; output follows inputs every cycle.
// Ports: req_vec (candidates), start_dec (one-hot start), found (any candidate), sel_dec (one-hot pick).
module rni_sel_bit_from_vec #(
  parameter int VEC_WIDTH = 8
) (
  input  logic [VEC_WIDTH-1:0] req_vec,
  input  logic [VEC_WIDTH-1:0] start_dec,
  output logic                 found,
  output logic [VEC_WIDTH-1:0] sel_dec
);

  logic [VEC_WIDTH-1:0] hi_mask;
  logic [VEC_WIDTH-1:0] masked;
  logic [VEC_WIDTH-1:0] hi_pick;
  logic [VEC_WIDTH-1:0] lo_pick;

  always_comb begin
    // start_dec - 1 sets every bit below the pointer; invert to keep bits at/above it.
    hi_mask = ~(start_dec - VEC_WIDTH'(1));
    masked  = req_vec & hi_mask;
    // x & -x isolates the lowest set bit.
    hi_pick = masked & (~masked + VEC_WIDTH'(1));
    lo_pick = req_vec & (~req_vec + VEC_WIDTH'(1));
    sel_dec = (|masked) ? hi_pick : lo_pick;
    found   = |req_vec;
  end

endmodule

// File: rtl/rni_rr_arb_ctl.sv
// Purpose : registered round-robin grant controller for RNI request/retry queues.
// Latency : request into an empty slot -> grant_vld one cycle later; one grant per cycle when streaming.
// Backpressure : grant held stable until a beat with grant_last is accepted; pointer moves only then.
// Ports: clk, rst_n (sync, active-low), req_vec, grant_rdy, grant_last,
//        grant_vld, grant_dec (one-hot), grant_idx (binary), arb_ptr (one-hot start pointer).
module rni_rr_arb_ctl
  import rni_misc_pkg::*;
#(
  parameter  int VEC_WIDTH      = 8,
  localparam int VEC_LOG2_WIDTH = $clog2(VEC_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [VEC_WIDTH-1:0]      req_vec,
  input  logic                      grant_rdy,
  input  logic                      grant_last,
  output logic                      grant_vld,
  output logic [VEC_WIDTH-1:0]      grant_dec,
  output logic [VEC_LOG2_WIDTH-1:0] grant_idx,
  output logic [VEC_WIDTH-1:0]      arb_ptr
);

  logic                 beat;
  logic                 done;
  logic                 hold;
  logic [VEC_WIDTH-1:0] ptr_nxt;
  logic [VEC_WIDTH-1:0] req_eff;
  logic                 found;
  logic [VEC_WIDTH-1:0] sel_dec;

  always_comb begin
    beat    = grant_vld & grant_rdy;
    done    = beat & grant_last;
    hold    = grant_vld & ~done;
    ptr_nxt = done ? VEC_WIDTH'(onehot_rotl1(MAX_W'(grant_dec), VEC_WIDTH)) : arb_ptr;
    // The requester completing this cycle is masked out of this cycle's reload.
    req_eff = req_vec & ~(done ? grant_dec : '0);
  end

  rni_sel_bit_from_vec #(
    .VEC_WIDTH (VEC_WIDTH)
  ) u_sel (
    .req_vec   (req_eff),
    .start_dec (ptr_nxt),
    .found     (found),
    .sel_dec   (sel_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_vld <= 1'b0;
      grant_dec <= '0;
      grant_idx <= '0;
      arb_ptr   <= VEC_WIDTH'(1);
    end else begin
      arb_ptr <= ptr_nxt;
      if (!hold) begin
        grant_vld <= found;
        grant_dec <= sel_dec;
        grant_idx <= VEC_LOG2_WIDTH'(onehot_encode(MAX_W'(sel_dec), VEC_WIDTH));
      end
    end
  end

endmodule

// File: tb/tb_rni_rr_arb_ctl.sv
module tb_rni_rr_arb_ctl;

  typedef struct {
    logic       vld;
    logic [7:0] dec;
    logic [2:0] idx;
    logic [7:0] ptr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_vec = 8'h00;
  logic       grant_rdy = 1'b0;
  logic       grant_last = 1'b0;
  logic       grant_vld;
  logic [7:0] grant_dec;
  logic [2:0] grant_idx;
  logic [7:0] arb_ptr;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rni_rr_arb_ctl #(.VEC_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_vec    (req_vec),
    .grant_rdy  (grant_rdy),
    .grant_last (grant_last),
    .grant_vld  (grant_vld),
    .grant_dec  (grant_dec),
    .grant_idx  (grant_idx),
    .arb_ptr    (arb_ptr)
  );

  task automatic chk(input string name, input int step_no, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%02h expected 0x%02h", name, step_no, act, exp);
    end
  endtask

  // Monitor: each expectation describes the DUT state right after the next rising edge.
  int mon_step = 0;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("grant_vld", mon_step, {7'b0, grant_vld}, {7'b0, e.vld});
      chk("grant_dec", mon_step, grant_dec, e.dec);
      chk("grant_idx", mon_step, {5'b0, grant_idx}, {5'b0, e.idx});
      chk("arb_ptr",   mon_step, arb_ptr, e.ptr);
      mon_step++;
    end
  end

  // Drive inputs at the falling edge and queue what the following rising edge must produce.
  task automatic step(input logic rst, input logic [7:0] req, input logic rdy, input logic last,
                      input logic evld, input logic [7:0] edec, input logic [2:0] eidx,
                      input logic [7:0] eptr);
    exp_t e;
    @(negedge clk);
    rst_n      = rst;
    req_vec    = req;
    grant_rdy  = rdy;
    grant_last = last;
    e.vld = evld; e.dec = edec; e.idx = eidx; e.ptr = eptr;
    exp_q.push_back(e);
  endtask

  initial begin
    //   rst  req    rdy  last  vld  dec    idx  ptr
    // Reset held two cycles with everyone requesting.
    step(0, 8'hFF, 0, 0,   0, 8'h00, 0, 8'h01);
    step(0, 8'hFF, 0, 0,   0, 8'h00, 0, 8'h01);
    step(1, 8'hFF, 0, 0,   1, 8'h01, 0, 8'h01);
    // Alternation between bit0 and bit7.
    step(1, 8'h81, 1, 1,   1, 8'h80, 7, 8'h02);
    step(1, 8'h81, 1, 1,   1, 8'h01, 0, 8'h01);
    step(1, 8'h81, 1, 1,   1, 8'h80, 7, 8'h02);
    step(1, 8'h81, 1, 1,   1, 8'h01, 0, 8'h01);
    // Backpressure: grant 0x04 held, pointer frozen, then complete.
    step(1, 8'h0C, 1, 1,   1, 8'h04, 2, 8'h02);
    step(1, 8'h0C, 0, 1,   1, 8'h04, 2, 8'h02);
    step(1, 8'h0C, 0, 0,   1, 8'h04, 2, 8'h02);
    step(1, 8'h0C, 0, 1,   1, 8'h04, 2, 8'h02);
    step(1, 8'h0C, 1, 1,   1, 8'h08, 3, 8'h08);
    // Multi-beat: non-final beats keep grant 0x02.
    step(1, 8'h06, 1, 1,   1, 8'h02, 1, 8'h10);
    step(1, 8'h06, 1, 0,   1, 8'h02, 1, 8'h10);
    step(1, 8'h06, 1, 0,   1, 8'h02, 1, 8'h10);
    step(1, 8'h06, 1, 1,   1, 8'h04, 2, 8'h04);
    // Request drops while granted: grant persists until done; then idle.
    step(1, 8'h00, 0, 0,   1, 8'h04, 2, 8'h04);
    step(1, 8'h00, 1, 1,   0, 8'h00, 0, 8'h08);
    // rdy/last with no valid grant are ignored; idle pointer does not move.
    step(1, 8'h00, 1, 1,   0, 8'h00, 0, 8'h08);
    // Wrap: winner at bit7 completes, pointer wraps to bit0.
    step(1, 8'h80, 0, 0,   1, 8'h80, 7, 8'h08);
    step(1, 8'hC1, 1, 1,   1, 8'h01, 0, 8'h01);
    step(1, 8'hC1, 1, 1,   1, 8'h40, 6, 8'h02);
    // Sole requester: masked on its done cycle, wins again one cycle later.
    step(1, 8'h40, 1, 1,   0, 8'h00, 0, 8'h80);
    step(1, 8'h40, 0, 0,   1, 8'h40, 6, 8'h80);
    // Mid-operation reset with a held grant, then restart from bit0.
    step(1, 8'h40, 0, 0,   1, 8'h40, 6, 8'h80);
    step(0, 8'h40, 0, 0,   0, 8'h00, 0, 8'h01);
    step(1, 8'h12, 0, 0,   1, 8'h02, 1, 8'h01);
    step(1, 8'h12, 1, 1,   1, 8'h10, 4, 8'h04);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
